// File: rtl/tft_pattern_gen_if.sv
// Panel-side signal bundle of tft_pattern_gen: pattern controls in,
// RGB565 pixel data, sync, data enable and raster position out.
interface tft_pattern_gen_if;
    logic [2:0]  mode;
    logic [2:0]  color_sel;
    logic [15:0] TFT_RGB;
    logic        TFT_HS;
    logic        TFT_VS;
    logic        TFT_DE;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        frame_start;
    logic [2:0]  active_mode;

    modport master (
        input  mode, color_sel,
        output TFT_RGB, TFT_HS, TFT_VS, TFT_DE, hcount, vcount, frame_start, active_mode
    );

    modport slave (
        output mode, color_sel,
        input  TFT_RGB, TFT_HS, TFT_VS, TFT_DE, hcount, vcount, frame_start, active_mode
    );
endinterface

// File: rtl/tft_pattern_gen.sv
// Parametrised RGB565 TFT timing and test-pattern generator: raster counters,
// divider-free segment counters, frame-synchronous pattern select and auto-cycle.
module tft_pattern_gen #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 40,
    parameter int H_SYNC      = 128,
    parameter int H_BP        = 88,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int COLS        = 2,
    parameter int ROWS        = 4,
    parameter int CHK_LOG2    = 5,
    parameter int GRAD_SHIFT  = 5,
    parameter int AUTO_FRAMES = 60
) (
    input  logic              Clk,
    input  logic              Rst_n,
    tft_pattern_gen_if.master tft
);
    localparam int          H_TOTAL   = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int          V_TOTAL   = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_START   = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_END     = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [11:0] V_START   = 12'(V_SYNC + V_BP);
    localparam logic [11:0] V_END     = 12'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [11:0] HS_END    = 12'(H_SYNC);
    localparam logic [11:0] VS_END    = 12'(V_SYNC);
    localparam logic [11:0] COL_LAST  = 12'(H_ACTIVE / COLS - 1);
    localparam logic [11:0] ROW_LAST  = 12'(V_ACTIVE / ROWS - 1);
    localparam logic [11:0] BAR_LAST  = 12'(H_ACTIVE / 8 - 1);
    localparam logic [15:0] AUTO_LAST = 16'(AUTO_FRAMES - 1);

    typedef enum logic [2:0] {
        PAT_SOLID, PAT_GRID, PAT_BARS, PAT_CHECK, PAT_GRAD, PAT_RSV5, PAT_RSV6, PAT_AUTO
    } pattern_e;

    function automatic logic [15:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = 16'h0000;
            3'd1:    palette = 16'h001F;
            3'd2:    palette = 16'hF800;
            3'd3:    palette = 16'hF81F;
            3'd4:    palette = 16'h07E0;
            3'd5:    palette = 16'h07FF;
            3'd6:    palette = 16'hFFE0;
            default: palette = 16'hFFFF;
        endcase
    endfunction

    logic [11:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [11:0] col_q, col_d, col_cnt_q, col_cnt_d;
    logic [11:0] row_q, row_d, row_cnt_q, row_cnt_d;
    logic [2:0]  bar_q, bar_d;
    logic [11:0] bar_cnt_q, bar_cnt_d;
    pattern_e    pat_q, pat_d;
    logic        auto_q, auto_d;
    logic [15:0] frm_q, frm_d;

    logic [15:0] rgb_q, rgb_d;
    logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [11:0] hcount_q, hcount_d, vcount_q, vcount_d;

    logic        line_end, frame_end, h_act, v_act, de;
    logic [11:0] x, y, lvl_full;
    logic [4:0]  lvl;
    logic [2:0]  grid_idx;
    logic [15:0] pixel;

    // NOTE: every signal gets a default first so no path through the block leaves it unassigned (no latch).
    always_comb begin
        line_end  = (hcnt_q == H_LAST);
        frame_end = line_end && (vcnt_q == V_LAST);
        h_act     = (hcnt_q >= H_START) && (hcnt_q < H_END);
        v_act     = (vcnt_q >= V_START) && (vcnt_q < V_END);
        hcnt_d    = line_end ? '0 : hcnt_q + 12'd1;
        vcnt_d    = vcnt_q;
        if (line_end) vcnt_d = frame_end ? '0 : vcnt_q + 12'd1;

        col_d     = '0;
        col_cnt_d = '0;
        bar_d     = '0;
        bar_cnt_d = '0;
        if (h_act) begin
            col_d     = col_q;
            col_cnt_d = col_cnt_q + 12'd1;
            if (col_cnt_q == COL_LAST) begin
                col_cnt_d = '0;
                col_d     = col_q + 12'd1;
            end
            // Bar 7 absorbs any remainder pixels at the right edge.
            bar_d     = bar_q;
            bar_cnt_d = bar_cnt_q + 12'd1;
            if (bar_q == 3'd7) begin
                bar_cnt_d = '0;
            end else if (bar_cnt_q == BAR_LAST) begin
                bar_cnt_d = '0;
                bar_d     = bar_q + 3'd1;
            end
        end

        row_d     = row_q;
        row_cnt_d = row_cnt_q;
        if (line_end) begin
            if (!v_act) begin
                row_d     = '0;
                row_cnt_d = '0;
            end else if (row_cnt_q == ROW_LAST) begin
                row_cnt_d = '0;
                row_d     = row_q + 12'd1;
            end else begin
                row_cnt_d = row_cnt_q + 12'd1;
            end
        end
    end

    // Mode is only looked at on the last clock of a frame, so a frame never changes pattern mid-way.
    always_comb begin
        pat_d  = pat_q;
        auto_d = auto_q;
        frm_d  = frm_q;
        if (frame_end) begin
            if (tft.mode != PAT_AUTO) begin
                pat_d  = pattern_e'(tft.mode);
                auto_d = 1'b0;
                frm_d  = '0;
            end else if (!auto_q) begin
                pat_d  = PAT_SOLID;
                auto_d = 1'b1;
                frm_d  = '0;
            end else if (frm_q == AUTO_LAST) begin
                frm_d  = '0;
                pat_d  = (pat_q == PAT_GRAD) ? PAT_SOLID : pattern_e'(pat_q + 3'd1);
            end else begin
                frm_d  = frm_q + 16'd1;
            end
        end
    end

    always_comb begin
        x        = hcnt_q - H_START;
        y        = vcnt_q - V_START;
        de       = h_act && v_act;
        grid_idx = row_q[2:0] * 3'(COLS) + col_q[2:0];
        lvl_full = x >> GRAD_SHIFT;
        lvl      = (lvl_full > 12'd31) ? 5'd31 : lvl_full[4:0];
        case (pat_q)
            PAT_GRID:  pixel = palette(grid_idx);
            PAT_BARS:  pixel = palette(bar_q);
            PAT_CHECK: pixel = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? 16'hFFFF : 16'h0000;
            PAT_GRAD:  pixel = {lvl, lvl, lvl[4], lvl};
            default:   pixel = palette(tft.color_sel);
        endcase
        rgb_d    = de ? pixel : '0;
        hcount_d = de ? x : '0;
        vcount_d = de ? y : '0;
        de_d     = de;
        hs_d     = (hcnt_q < HS_END) ? HS_POL : ~HS_POL;
        vs_d     = (vcnt_q < VS_END) ? VS_POL : ~VS_POL;
        fs_d     = (hcnt_q == '0) && (vcnt_q == '0);
    end

    // NOTE: non-blocking assignments make every register update from the same pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            col_q     <= '0;
            col_cnt_q <= '0;
            row_q     <= '0;
            row_cnt_q <= '0;
            bar_q     <= '0;
            bar_cnt_q <= '0;
            pat_q     <= PAT_SOLID;
            auto_q    <= 1'b0;
            frm_q     <= '0;
            rgb_q     <= '0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            de_q      <= 1'b0;
            fs_q      <= 1'b0;
            hcount_q  <= '0;
            vcount_q  <= '0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            col_q     <= col_d;
            col_cnt_q <= col_cnt_d;
            row_q     <= row_d;
            row_cnt_q <= row_cnt_d;
            bar_q     <= bar_d;
            bar_cnt_q <= bar_cnt_d;
            pat_q     <= pat_d;
            auto_q    <= auto_d;
            frm_q     <= frm_d;
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            fs_q      <= fs_d;
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
        end
    end

    assign tft.TFT_RGB     = rgb_q;
    assign tft.TFT_HS      = hs_q;
    assign tft.TFT_VS      = vs_q;
    assign tft.TFT_DE      = de_q;
    assign tft.hcount      = hcount_q;
    assign tft.vcount      = vcount_q;
    assign tft.frame_start = fs_q;
    assign tft.active_mode = pat_q;
endmodule

// File: doc/tft_pattern_gen.md
Name: tft_pattern_gen

Overview:
- Parametrised RGB565 TFT timing and test-pattern generator for RGB-LCD panels.
- Generalises the fixed 800x480 solid-colour top: every timing value is a parameter, the colour grid size is configurable, and it adds several pattern modes, frame-synchronous mode switching and an auto-cycle mode.
- Sits between the pixel-clock PLL output and the panel pins, and replaces the separate controller plus the combinational colour mux.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, HS pulse width (clocks)
- H_BP, 88, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VS pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, HS active level
- VS_POL, 0, VS active level
- COLS, 2, grid columns; H_ACTIVE divisible by COLS
- ROWS, 4, grid rows; V_ACTIVE divisible by ROWS
- CHK_LOG2, 5, checker square size = 2^CHK_LOG2 pixels
- GRAD_SHIFT, 5, gradient step = 2^GRAD_SHIFT pixels
- AUTO_FRAMES, 60, frames per pattern in auto mode (>=1)

Ports:
- Clk, input, 1, pixel clock
- Rst_n, input, 1, async active-low reset
- mode, input, 3, pattern select
- color_sel, input, 3, palette index for solid mode
- TFT_RGB, output, 16, pixel data (RGB565)
- TFT_HS, output, 1, horizontal sync
- TFT_VS, output, 1, vertical sync
- TFT_DE, output, 1, data enable
- hcount, output, 12, active-area x, aligned with DE
- vcount, output, 12, active-area y, aligned with DE
- frame_start, output, 1, one-cycle pulse on the first clock of each frame
- active_mode, output, 3, pattern currently displayed

Behaviour:
- Clock and reset: single clock Clk; Rst_n is asynchronous, active-low.
- Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Counters:
  - hcnt runs 0..H_TOTAL-1 and wraps to 0.
  - vcnt increments when hcnt wraps and runs 0..V_TOTAL-1, then wraps to 0.
- Timing regions:
  - HS active for hcnt < H_SYNC; VS active for vcnt < V_SYNC.
  - DE when hcnt is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vcnt is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - x = hcnt-(H_SYNC+H_BP), y = vcnt-(V_SYNC+V_BP).
- Pipeline: all outputs are registered with exactly 1 cycle latency from the counter state and stay mutually aligned. hcount, vcount and TFT_RGB are 0 whenever DE is 0.
- Reset values: counters 0, TFT_DE 0, TFT_HS = ~HS_POL, TFT_VS = ~VS_POL, TFT_RGB 0, hcount/vcount 0, frame_start 0, active_mode 0, auto frame counter 0.
- Frame start: frame_start = 1 on the output cycle corresponding to hcnt=0, vcnt=0, including the first one after reset release.
- Palette (index 0..7): 0000, 001F, F800, F81F, 07E0, 07FF, FFE0, FFFF (black, blue, red, purple, green, cyan, yellow, white).
- Modes, by active_mode:
  - 0 solid: palette[color_sel]; color_sel is sampled live, every pixel.
  - 1 grid: palette[(row*COLS+col) mod 8], with col = x/(H_ACTIVE/COLS) and row = y/(V_ACTIVE/ROWS).
  - 2 vertical bars: 8 equal bars, palette[x/(H_ACTIVE/8)]. Remainder pixels at the right edge take bar 7.
  - 3 checker: FFFF if bit0 of ((x>>CHK_LOG2) XOR (y>>CHK_LOG2)) is 1, else 0000.
  - 4 grey gradient: L = min(x>>GRAD_SHIFT, 31); RGB = {L[4:0], L[4:0], L[4], L[4:0]}.
  - 5, 6: reserved, behave as mode 0.
  - 7 auto: the displayed pattern steps 0→1→2→3→4→0 every AUTO_FRAMES frames. Stepping happens at the frame boundary, and active_mode reports the stepped pattern.
- Division rule: no runtime dividers.
  - col, row and bar indices come from running segment counters. Each counter clears at line start (col/bar) or frame start (row) and advances when its in-segment count reaches the segment width.
  - Segment widths are elaboration constants.
- Mode latching: mode is sampled only at hcnt=H_TOTAL-1, vcnt=V_TOTAL-1.
  - A change takes effect at the next frame_start; mid-frame changes never alter the current frame.
  - Entering mode 7 starts at pattern 0 with the frame counter cleared.
  - Leaving mode 7 applies the newly sampled mode directly.
- Reset mid-frame: all state returns immediately to the reset values. Timing restarts at hcnt=vcnt=0 on the first clock after release.

Test Plan:
- Reset and timing:
  - Stimulus: small parameters (H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1).
  - Check: release reset; H_TOTAL=14, V_TOTAL=7; HS low for 2 of every 14 clocks; DE high for 8 clocks per line on 4 lines; frame_start every 98 clocks with the first on cycle 1 after release.
- Solid mode and blanking:
  - Stimulus: mode=0, color_sel=6.
  - Check: every DE pixel is FFE0. Switch color_sel to 1 mid-line → DE pixels become 001F on the next pixel; all non-DE pixels are 0000.
- Grid mode:
  - Stimulus: defaults, mode=1.
  - Check: pixel (239,67)=0000, (400,67)=001F, (0,120)=F800, (799,479)=FFFF. The same row/column boundary checks hold with small parameters.
- Mode switch mid-frame:
  - Stimulus: mode 0→3 at line 2.
  - Check: the remainder of the current frame stays solid. The next frame is checker; with CHK_LOG2=1 and small parameters, pixel (0,0)=0000 and (2,0)=FFFF.
- Auto mode:
  - Stimulus: AUTO_FRAMES=2, mode=7.
  - Check: active_mode sequence per frame is 0,0,1,1,2,2,3,3,4,4,0. The gradient frame with GRAD_SHIFT=1 gives x=6 → L=3 → RGB 18C3.
- Reset mid-frame:
  - Stimulus: assert Rst_n low at x=5, y=2 in mode 2.
  - Check: outputs are immediately at their reset values. After release, frame_start is seen on the first clock, active_mode=0, and timing matches the first scenario.
